// File: rtl/fc_weight_loader_pkg.sv
// fc_pkg: shared word/address widths and the loader FSM state encoding.
package fc_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
endpackage

// File: rtl/fc_weight_loader_if.sv
// fc_weight_loader_if: load stream + row read bus; master = sequencer/source, slave = loader. Optional checksum under FC_WLOAD_CHECKSUM_EN.
interface fc_weight_loader_if
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = fc_pkg::DATA_WIDTH,
    parameter int OUTPUT_NODES = 84
);
    logic                               load_start;
    logic [DATA_WIDTH-1:0]              in_data;
    logic                               in_valid;
    logic                               in_ready;
    logic                               load_done;
    logic [ADDR_WIDTH-1:0]              address;
    logic [OUTPUT_NODES*DATA_WIDTH-1:0] weights;
`ifdef FC_WLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]              checksum;
`endif
    modport master (
        output load_start, in_data, in_valid, address,
        input  in_ready, load_done, weights
`ifdef FC_WLOAD_CHECKSUM_EN
        , input checksum
`endif
    );
    modport slave (
        input  load_start, in_data, in_valid, address,
        output in_ready, load_done, weights
`ifdef FC_WLOAD_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/fc_weight_loader_row_assembler.sv
// fc_row_assembler: shifts accepted words into one row; ports i_clear/i_xfer/i_data in, o_row/o_row_valid (pulse after last node)/o_last_node out.
module fc_row_assembler #(
    parameter int DATA_WIDTH   = 32,
    parameter int OUTPUT_NODES = 84
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_clear,
    input  logic                               i_xfer,
    input  logic [DATA_WIDTH-1:0]              i_data,
    output logic [OUTPUT_NODES*DATA_WIDTH-1:0] o_row,
    output logic                               o_row_valid,
    output logic                               o_last_node
);
    localparam int NW  = OUTPUT_NODES > 1 ? $clog2(OUTPUT_NODES) : 1;
    localparam int ROW = OUTPUT_NODES * DATA_WIDTH;
    logic [NW-1:0]  r_node;
    logic [ROW-1:0] r_row;
    logic           r_row_valid;
    assign o_last_node = r_node == NW'(OUTPUT_NODES - 1);
    assign o_row       = r_row;
    assign o_row_valid = r_row_valid;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_node      <= '0;
            r_row_valid <= 1'b0;
        end else begin
            r_row_valid <= i_xfer && o_last_node;
            r_node      <= i_clear ? '0 : !i_xfer ? r_node : o_last_node ? '0 : r_node + 1'b1;
        end
    end
    // New words enter at the top; after OUTPUT_NODES shifts node 0 sits in the low slice.
    always_ff @(posedge clk)
        if (i_xfer) r_row <= (r_row >> DATA_WIDTH) | (ROW'(i_data) << (ROW - DATA_WIDTH));
endmodule

// File: rtl/fc_weight_loader.sv
// fc_weight_loader: streams INPUT_NODES rows of OUTPUT_NODES words into row storage and serves one row per cycle.
// Ports: clk, reset (sync, active-high), bus (fc_weight_loader_if.slave). Optional checksum output with FC_WLOAD_CHECKSUM_EN.
module fc_weight_loader
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH   = fc_pkg::DATA_WIDTH,
    parameter int INPUT_NODES  = 120,
    parameter int OUTPUT_NODES = 84
) (
    input  logic             clk,
    input  logic             reset,
    fc_weight_loader_if.slave bus
);
    localparam int RW  = INPUT_NODES > 1 ? $clog2(INPUT_NODES) : 1;
    localparam int ROW = OUTPUT_NODES * DATA_WIDTH;
    state_t         r_state, w_next;
    logic [RW-1:0]  r_row_cnt, r_wr_row;
    logic [ROW-1:0] r_mem [INPUT_NODES];
    logic [ROW-1:0] r_weights, w_row;
    logic           r_done, w_xfer, w_row_valid, w_last_node, w_last_word;
    assign w_xfer      = bus.in_valid && bus.in_ready;
    assign w_last_word = w_xfer && w_last_node && r_row_cnt == RW'(INPUT_NODES - 1);
    fc_row_assembler #(.DATA_WIDTH(DATA_WIDTH), .OUTPUT_NODES(OUTPUT_NODES)) u_row (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (bus.load_start),
        .i_xfer     (w_xfer),
        .i_data     (bus.in_data),
        .o_row      (w_row),
        .o_row_valid(w_row_valid),
        .o_last_node(w_last_node)
    );
    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;
    always_comb
        w_next = bus.load_start ? LOAD : (r_state == LOAD && w_last_word) ? READY : r_state;
    always_comb begin
        bus.in_ready  = r_state == LOAD && !bus.load_start;
        bus.load_done = r_done;
        bus.weights   = r_weights;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_cnt <= '0;
            r_wr_row  <= '0;
            r_done    <= 1'b0;
            r_weights <= '0;
        end else begin
            r_row_cnt <= bus.load_start ? '0 : (w_xfer && w_last_node) ? r_row_cnt + 1'b1 : r_row_cnt;
            r_wr_row  <= (w_xfer && w_last_node) ? r_row_cnt : r_wr_row;
            // Done follows the final row commit by one cycle; load_start always wins.
            r_done    <= !bus.load_start && (r_done || (w_row_valid && r_wr_row == RW'(INPUT_NODES - 1)));
            r_weights <= (r_state == READY && bus.address < 8'(INPUT_NODES)) ? r_mem[bus.address[RW-1:0]] : '0;
        end
    end
    always_ff @(posedge clk)
        if (w_row_valid && !reset) r_mem[r_wr_row] <= w_row;
`ifdef FC_WLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    assign bus.checksum = r_sum;
    always_ff @(posedge clk)
        r_sum <= (reset || bus.load_start) ? '0 : w_xfer ? r_sum + bus.in_data : r_sum;
`endif
endmodule

// File: doc/fc_weight_loader.md
FC_WEIGHT_LOADER -- requirements
Module: fc_weight_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one IEEE-754 single-precision weight word.
REQ-002 Parameter INPUT_NODES, default 120, number of weight rows; must be at most 254.
REQ-003 Parameter OUTPUT_NODES, default 84, number of words per row.
REQ-004 Port clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port load_start  input  1  one-cycle pulse that begins or restarts a weight load.
REQ-007 Port in_data  input  DATA_WIDTH  incoming weight word.
REQ-008 Port in_valid  input  1  in_data is valid this cycle.
REQ-009 Port in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port load_done  output  1  level; high when the full weight set is resident.
REQ-011 Port address  input  8  row select from the FC sequencer.
REQ-012 Port weights  output  OUTPUT_NODES*DATA_WIDTH  selected row; node j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-013 The FSM SHALL have three states: IDLE, LOAD, READY.
REQ-014 Transitions: IDLE -> LOAD on load_start; LOAD -> READY on the accepted last word; READY -> LOAD on load_start; LOAD -> LOAD (restart) on load_start.
REQ-015 A word transfer SHALL occur when in_valid and in_ready are both high in the same cycle.
REQ-016 in_ready SHALL be high only in LOAD, and low in the cycle that load_start is sampled.
REQ-017 Word order SHALL be row-major: row 0 node 0, row 0 node 1, ..., row INPUT_NODES-1 node OUTPUT_NODES-1.
REQ-018 A node counter SHALL wrap from OUTPUT_NODES-1 to 0 and advance the row counter.
REQ-019 Each completed row SHALL be committed to storage in the cycle after its last word is accepted.
REQ-020 The total load SHALL be exactly INPUT_NODES*OUTPUT_NODES transfers.
REQ-021 load_done SHALL rise in the cycle after the final row commit and stay high until reset or load_start.
REQ-022 A load_start pulse in LOAD or READY SHALL clear the counters and drop load_done in the next cycle.
REQ-023 A load_start pulse in LOAD or READY SHALL leave stored rows intact; each row is overwritten only as its new data is committed.
REQ-024 Read latency SHALL be one cycle: weights in cycle N+1 reflects address sampled at cycle N.
REQ-025 weights SHALL be all-zero when address >= INPUT_NODES (including 8'hFE and 8'hFF) or when the state is not READY.
REQ-026 An in_valid asserted outside LOAD SHALL be ignored, with no transfer and no state change.

Reset
REQ-027 On reset the state SHALL be IDLE and the counters SHALL be 0.
REQ-028 On reset in_ready=0, load_done=0 and weights=0.
REQ-029 Stored row contents are not required to be cleared by reset.
REQ-030 Reset SHALL take priority over load_start and any in-flight transfer.

Configuration
REQ-031 With macro FC_WLOAD_CHECKSUM_EN defined, an extra output port checksum (DATA_WIDTH bits) SHALL be present.
REQ-032 checksum SHALL be the modulo-2^DATA_WIDTH integer sum of all words accepted since the last load_start, cleared by reset and by load_start.
REQ-033 checksum SHALL update in the cycle after each transfer.
REQ-034 Without FC_WLOAD_CHECKSUM_EN, the checksum port and its adder SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 A shared package fc_pkg SHALL hold DATA_WIDTH, the address width (8), and the FSM state enumeration.
REQ-036 One sub-module, fc_row_assembler, SHALL hold the shift register and node counter that build one row and emit a row_valid pulse.

Verification
REQ-037 Parameters INPUT_NODES=4, OUTPUT_NODES=3; load_start, then words 1..12 with in_valid held high -> load_done high in the cycle after the row-3 commit; address=2 -> weights={9,8,7} (node 0 = 7) one cycle later.
REQ-038 Same load with in_valid toggling every other cycle -> identical stored data; load_done asserted only after 12 transfers.
REQ-039 Read address=4, then 8'hFF, then 8'hFE -> weights=0 each time; before any load, address=0 -> weights=0.
REQ-040 load_start after 5 words, then words 101..112 -> address=0 returns {103,102,101}; load_done low until the 12th new word is accepted.
REQ-041 Reset asserted mid-load -> next cycle in_ready=0, load_done=0, state IDLE; in_valid while IDLE -> no transfer.
REQ-042 With FC_WLOAD_CHECKSUM_EN defined, words 1..12 -> checksum=78; words of 32'hFFFFFFFF twelve times -> checksum=32'hFFFFFFF4.
